// File: rtl/tay_addsub_round_buf.sv
// Round-to-nearest-even stage for the Taylor add/sub result, followed by a small
// output FIFO with a credit signal (accept_o) for the non-stallable upstream.
module tay_addsub_round_buf #(
    parameter int E_DW      = 8,
    parameter int F_DW      = 7,
    parameter int DEPTH     = 4,
    parameter int LOOKAHEAD = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    input  logic                   s_i,
    input  logic [E_DW-1:0]        e_i,
    input  logic [F_DW+4:0]        f_i,
    input  logic                   isOverflow_i,
    input  logic                   isUnderflow_i,
    input  logic                   isToRound_i,
    output logic                   accept_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [E_DW+F_DW:0]     res_o,
    output logic [2:0]             flags_o,
    output logic                   drop_err_o
);
    localparam int W  = 1 + E_DW + F_DW;
    localparam int EW = W + 3;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Handshake: an entry leaves the FIFO on a rising clk edge where
    // out_valid_o & out_ready_i; res_o/flags_o hold steady while stalled.

    logic              stage_valid_q, stage_valid_d;
    logic [W-1:0]      stage_word_q, stage_word_d;
    logic [2:0]        stage_flags_q, stage_flags_d;
    logic [EW-1:0]     mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              drop_err_q, drop_err_d;

    logic                 lsb, g, st, inc, ovf, inexact;
    logic [E_DW+F_DW-1:0] sum;
    logic [W-1:0]         word;
    logic                 unused_f_top;

    // The top extended-fraction bit is never set by the add/sub normaliser.
    assign unused_f_top = f_i[F_DW+4];

    always_comb begin
        lsb     = f_i[3];
        g       = f_i[2];
        st      = f_i[1] | f_i[0];
        inc     = g & (st | lsb);
        sum     = {e_i, f_i[F_DW+2:3]} + (E_DW+F_DW)'(inc);
        word    = {s_i, e_i, f_i[F_DW+2:3]};
        ovf     = isOverflow_i;
        inexact = 1'b0;
        if (isToRound_i) begin
            inexact = g | st;
            // Fraction carry ripples into the exponent through the concatenation.
            if ((sum[E_DW+F_DW-1:F_DW] == {E_DW{1'b1}}) || isOverflow_i) begin
                word = {s_i, {E_DW{1'b1}}, {F_DW{1'b0}}};
                ovf  = 1'b1;
            end else begin
                word = {s_i, sum};
                ovf  = 1'b0;
            end
        end
        stage_valid_d = valid_i;
        stage_word_d  = stage_word_q;
        stage_flags_d = stage_flags_q;
        if (valid_i) begin
            stage_word_d  = word;
            stage_flags_d = {ovf, isUnderflow_i, inexact};
        end
    end

    logic full, push, pop, wr_en, drop;
    logic [31:0] used;

    always_comb begin
        out_valid_o = (count_q != '0);
        full        = (count_q == CW'(DEPTH));
        push        = stage_valid_q;
        pop         = out_valid_o & out_ready_i;
        wr_en       = push & (~full | pop);
        drop        = push & full & ~pop;
        count_d     = count_q + CW'(wr_en) - CW'(pop);
        wr_ptr_d    = wr_ptr_q + AW'(wr_en);
        rd_ptr_d    = rd_ptr_q + AW'(pop);
        drop_err_d  = drop_err_q | drop;
        // free = DEPTH - count - stage_valid, rearranged to stay non-negative.
        used        = 32'(count_q) + 32'(stage_valid_q);
        accept_o    = (used + 32'(LOOKAHEAD)) <= 32'(DEPTH);
        res_o       = mem_q[rd_ptr_q][EW-1:3];
        flags_o     = mem_q[rd_ptr_q][2:0];
        drop_err_o  = drop_err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            drop_err_q    <= 1'b0;
        end else begin
            stage_valid_q <= stage_valid_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            drop_err_q    <= drop_err_d;
        end
    end

    // Datapath registers and storage carry no reset; validity lives in the counters.
    always_ff @(posedge clk) begin
        stage_word_q  <= stage_word_d;
        stage_flags_q <= stage_flags_d;
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {stage_word_q, stage_flags_q};
        end
    end

endmodule

// File: tb/tb_tay_addsub_round_buf.sv
// Bench for tay_addsub_round_buf: directed rounding vectors, random vectors,
// credit-honouring backpressure, forced drop and mid-run reset.
module tb_tay_addsub_round_buf;
  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [11:0] f;
    logic        ovf;
    logic        unf;
    logic        rnd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic        s_i = 1'b0;
  logic [7:0]  e_i = '0;
  logic [11:0] f_i = '0;
  logic        isOverflow_i = 1'b0;
  logic        isUnderflow_i = 1'b0;
  logic        isToRound_i = 1'b0;
  logic        accept_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [15:0] res_o;
  logic [2:0]  flags_o;
  logic        drop_err_o;

  int checks = 0;
  int errors = 0;
  int pops = 0;
  logic [18:0] exp_q[$];
  logic [18:0] mon_exp;

  tay_addsub_round_buf #(.E_DW(8), .F_DW(7), .DEPTH(4), .LOOKAHEAD(3)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .s_i(s_i), .e_i(e_i), .f_i(f_i),
    .isOverflow_i(isOverflow_i), .isUnderflow_i(isUnderflow_i), .isToRound_i(isToRound_i),
    .accept_o(accept_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .res_o(res_o), .flags_o(flags_o), .drop_err_o(drop_err_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic [7:0] e, input logic hid,
                              input logic [6:0] frac, input logic g, input logic [1:0] st,
                              input logic ovf, input logic unf, input logic rnd);
    vec_t v;
    v.s = s; v.e = e; v.f = {1'b0, hid, frac, g, st};
    v.ovf = ovf; v.unf = unf; v.rnd = rnd;
    return v;
  endfunction

  // Reference: treat {e,frac} as one integer magnitude and add the rounding bit.
  function automatic logic [18:0] model(input vec_t v);
    int mag;
    logic g, st, up, of;
    logic [15:0] r;
    g  = v.f[2];
    st = v.f[1] | v.f[0];
    if (!v.rnd) return {v.s, v.e, v.f[9:3], v.ovf, v.unf, 1'b0};
    up  = g & (st | v.f[3]);
    mag = int'(v.e) * 128 + int'(v.f[9:3]) + int'(up);
    if (v.ovf || mag >= 255 * 128) begin
      r = {v.s, 8'hFF, 7'h00};
      of = 1'b1;
    end else begin
      r = {v.s, mag[14:0]};
      of = 1'b0;
    end
    return {r, of, v.unf, g | st};
  endfunction

  function automatic vec_t rand_vec();
    logic [7:0] e;
    e = 8'($urandom_range(0, 254));
    return mk(1'($urandom_range(0, 1)), e, e != 8'h00, 7'($urandom_range(0, 127)),
              1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b1);
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    valid_i = 1'b1; s_i = v.s; e_i = v.e; f_i = v.f;
    isOverflow_i = v.ovf; isUnderflow_i = v.unf; isToRound_i = v.rnd;
  endtask

  task automatic idle();
    valid_i = 1'b0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    check_eq("drain_timeout", exp_q.size(), 0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && out_valid_o && out_ready_i) begin
      pops++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_pop", 32'(out_valid_o), 0);
      end else begin
        mon_exp = exp_q.pop_front();
        check_eq("result", {13'b0, res_o, flags_o}, {13'b0, mon_exp});
      end
    end
  end

  vec_t        dv[9];
  logic [18:0] dx[9];

  initial begin
    vec_t v, p0, p1;
    logic v0, v1;
    int p;

    dv[0] = mk(0, 8'h7F, 1, 7'h55, 1, 2'b01, 0, 0, 1); dx[0] = {16'h3FD6, 3'b001};
    dv[1] = mk(0, 8'h7F, 1, 7'h54, 1, 2'b00, 0, 0, 1); dx[1] = {16'h3FD4, 3'b001};
    dv[2] = mk(0, 8'h7F, 1, 7'h55, 1, 2'b00, 0, 0, 1); dx[2] = {16'h3FD6, 3'b001};
    dv[3] = mk(0, 8'h7F, 1, 7'h7F, 1, 2'b01, 0, 0, 1); dx[3] = {16'h4000, 3'b001};
    dv[4] = mk(0, 8'h00, 0, 7'h7F, 1, 2'b01, 0, 0, 1); dx[4] = {16'h0080, 3'b001};
    dv[5] = mk(0, 8'hFE, 1, 7'h7F, 1, 2'b01, 0, 0, 1); dx[5] = {16'h7F80, 3'b101};
    dv[6] = mk(1, 8'h10, 1, 7'h22, 0, 2'b00, 1, 0, 1); dx[6] = {16'hFF80, 3'b100};
    dv[7] = mk(0, 8'hFF, 1, 7'h40, 1, 2'b00, 0, 0, 0); dx[7] = {16'h7FC0, 3'b000};
    dv[8] = mk(1, 8'h00, 0, 7'h10, 0, 2'b10, 0, 1, 1); dx[8] = {16'h8010, 3'b011};

    repeat (3) tick();
    rst = 1'b0;
    check_eq("rst_out_valid", 32'(out_valid_o), 0);
    check_eq("rst_drop_err", 32'(drop_err_o), 0);
    check_eq("rst_accept", 32'(accept_o), 1);

    // directed vectors, first one also checks the two-cycle latency
    out_ready_i = 1'b1;
    drive(dv[0]); exp_q.push_back(dx[0]);
    tick(); idle();
    check_eq("lat_edge1", 32'(out_valid_o), 0);
    tick();
    check_eq("lat_edge2", 32'(out_valid_o), 1);
    for (int i = 1; i < 9; i++) begin
      drive(dv[i]); exp_q.push_back(dx[i]);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      v = rand_vec(); drive(v); exp_q.push_back(model(v));
      tick();
    end
    idle();
    wait_empty();

    // backpressure with a two-register upstream that honours accept_o
    out_ready_i = 1'b0;
    v0 = 1'b0; v1 = 1'b0; p0 = '0; p1 = '0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) check_eq("accept_free3", 32'(accept_o), 1);
      if (i == 4) check_eq("accept_free2", 32'(accept_o), 0);
      if (v1) drive(p1); else idle();
      p1 = p0; v1 = v0;
      v0 = accept_o;
      if (v0) begin
        p0 = rand_vec();
        exp_q.push_back(model(p0));
      end
      tick();
    end
    idle();
    check_eq("full_valid", 32'(out_valid_o), 1);
    check_eq("full_nodrop", 32'(drop_err_o), 0);
    check_eq("full_accept", 32'(accept_o), 0);

    // push and pop together while full
    v = rand_vec(); drive(v); exp_q.push_back(model(v));
    tick(); idle();
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    tick();
    check_eq("pushpop_nodrop", 32'(drop_err_o), 0);
    p = pops;
    out_ready_i = 1'b1;
    repeat (4) tick();
    check_eq("drain_count", 32'(pops - p), 4);
    check_eq("drain_empty", 32'(out_valid_o), 0);
    check_eq("drain_queue", exp_q.size(), 0);

    // ignore credit: six results into a four-entry FIFO
    out_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      v = rand_vec(); drive(v);
      if (i < 4) exp_q.push_back(model(v));
      tick();
    end
    idle();
    repeat (3) tick();
    check_eq("drop_set", 32'(drop_err_o), 1);
    repeat (3) tick();
    check_eq("drop_sticky", 32'(drop_err_o), 1);
    p = pops;
    out_ready_i = 1'b1;
    repeat (6) tick();
    check_eq("drop_retained", 32'(pops - p), 4);
    check_eq("drop_empty", 32'(out_valid_o), 0);
    check_eq("drop_after_drain", 32'(drop_err_o), 1);

    // reset with results queued and in flight
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v = rand_vec(); drive(v);
      tick();
    end
    idle();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst2_out_valid", 32'(out_valid_o), 0);
    check_eq("rst2_drop_err", 32'(drop_err_o), 0);
    check_eq("rst2_accept", 32'(accept_o), 1);
    out_ready_i = 1'b1;
    repeat (5) tick();
    check_eq("rst2_quiet", 32'(out_valid_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
